// File: rtl/microwave_if.sv
// Bundles the keypad/door/timer inputs and the control outputs of the
// microwave oven controller.
interface microwave_if;
    logic        tick;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop_clr;
    logic        door_closed;
    logic        timer_zero;
    logic [15:0] preset;
    logic        load;
    logic        count_en;
    logic        magnetron;
    logic        lamp;
    logic        beep;
    logic [1:0]  state;

    modport master (
        output tick, key_valid, key_digit, start, stop_clr, door_closed, timer_zero,
        input  preset, load, count_en, magnetron, lamp, beep, state
    );

    modport slave (
        input  tick, key_valid, key_digit, start, stop_clr, door_closed, timer_zero,
        output preset, load, count_en, magnetron, lamp, beep, state
    );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave oven controller: BCD time entry, cook/pause/done sequencing and
// control of the external mm:ss down-counter chain.
module microwave_ctrl (
    input  logic        clk,
    input  logic        rst,
    microwave_if.slave  mw
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r, state_nx;
    logic [15:0] preset_r, preset_nx;
    logic        load_r, load_nx;
    logic        magnetron_r, magnetron_nx;
    logic        lamp_r, lamp_nx;
    logic        beep_r, beep_nx;
    logic [1:0]  done_cnt_r, done_cnt_nx;
    logic        start_ok_s;

    // A start is only meaningful with a closed door and a valid, non-zero mm:ss entry.
    assign start_ok_s = mw.door_closed && (preset_r != 16'h0000) && (preset_r[7:4] <= 4'd5);

    // Next-state, preset, DONE tick counter and registered-output decode.
    always_comb begin
        state_nx     = state_r;
        preset_nx    = preset_r;
        load_nx      = 1'b0;
        done_cnt_nx  = 2'd0;
        magnetron_nx = 1'b0;
        lamp_nx      = 1'b0;
        beep_nx      = 1'b0;

        case (state_r)
            IDLE: begin
                if (mw.stop_clr) begin
                    preset_nx = 16'h0000;
                end else if (mw.start && start_ok_s) begin
                    state_nx = COOK;
                    load_nx  = 1'b1;
                end else if (mw.key_valid && (mw.key_digit <= 4'd9)) begin
                    preset_nx = {preset_r[11:0], mw.key_digit};
                end else begin
                    preset_nx = preset_r;
                end
            end
            COOK: begin
                // timer_zero is stale during the load cycle; the chain has not loaded yet.
                if (mw.stop_clr) begin
                    state_nx = PAUSE;
                end else if (mw.timer_zero && !load_r) begin
                    state_nx = DONE;
                end else if (!mw.door_closed) begin
                    state_nx = PAUSE;
                end else begin
                    state_nx = COOK;
                end
            end
            PAUSE: begin
                if (mw.stop_clr) begin
                    state_nx  = IDLE;
                    preset_nx = 16'h0000;
                end else if (mw.start && mw.door_closed) begin
                    state_nx = COOK;
                end else begin
                    state_nx = PAUSE;
                end
            end
            DONE: begin
                if (mw.stop_clr) begin
                    state_nx  = IDLE;
                    preset_nx = 16'h0000;
                end else if (mw.tick) begin
                    if (done_cnt_r == 2'd2) begin
                        state_nx  = IDLE;
                        preset_nx = 16'h0000;
                    end else begin
                        done_cnt_nx = done_cnt_r + 2'd1;
                    end
                end else begin
                    done_cnt_nx = done_cnt_r;
                end
            end
            default: begin
                state_nx  = IDLE;
                preset_nx = 16'h0000;
            end
        endcase

        case (state_nx)
            IDLE:    lamp_nx = ~mw.door_closed;
            COOK: begin
                magnetron_nx = 1'b1;
                lamp_nx      = 1'b1;
            end
            PAUSE:   lamp_nx = 1'b1;
            DONE:    beep_nx = 1'b1;
            default: lamp_nx = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            preset_r    <= 16'h0000;
            load_r      <= 1'b0;
            magnetron_r <= 1'b0;
            lamp_r      <= ~mw.door_closed;
            beep_r      <= 1'b0;
            done_cnt_r  <= 2'd0;
        end else begin
            state_r     <= state_nx;
            preset_r    <= preset_nx;
            load_r      <= load_nx;
            magnetron_r <= magnetron_nx;
            lamp_r      <= lamp_nx;
            beep_r      <= beep_nx;
            done_cnt_r  <= done_cnt_nx;
        end
    end

    // The load cycle masks the tick so the freshly loaded time is not decremented.
    assign mw.count_en  = mw.tick & (state_r == COOK) & mw.door_closed & ~load_r;
    assign mw.state     = state_r;
    assign mw.preset    = preset_r;
    assign mw.load      = load_r;
    assign mw.magnetron = magnetron_r;
    assign mw.lamp      = lamp_r;
    assign mw.beep      = beep_r;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Scoreboard bench for microwave_ctrl: directed scenarios plus random stimulus
// checked against a behavioural model of the oven.
module tb_microwave_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    microwave_if mw ();

    microwave_ctrl dut (
        .clk (clk),
        .rst (rst),
        .mw  (mw.slave)
    );

    typedef struct packed {
        logic [15:0] preset;
        logic        load;
        logic        mag;
        logic        lamp;
        logic        beep;
        logic [1:0]  state;
        logic        ce;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: mode 0 idle, 1 cooking, 2 paused, 3 finished.
    int m_mode  = 0;
    int m_d[4]  = '{0, 0, 0, 0};
    int m_load  = 0;
    int m_ticks = 0;
    bit door    = 1'b1;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic issue(input bit r, input bit tk, input bit kv, input bit [3:0] kd,
                         input bit st, input bit sc, input bit dc, input bit tz);
        exp_t e;
        int   prev_load;
        bit   entry_ok;
        @(negedge clk);
        rst            = r;
        mw.tick        = tk;
        mw.key_valid   = kv;
        mw.key_digit   = kd;
        mw.start       = st;
        mw.stop_clr    = sc;
        mw.door_closed = dc;
        mw.timer_zero  = tz;

        e.ce      = tk && (m_mode == 1) && dc && (m_load == 0);
        prev_load = m_load;
        m_load    = 0;
        entry_ok  = dc && ((m_d[0] + m_d[1] + m_d[2] + m_d[3]) != 0) && (m_d[2] <= 5);

        if (r) begin
            m_mode = 0;
            m_d    = '{0, 0, 0, 0};
        end else if (m_mode == 0) begin
            if (sc) m_d = '{0, 0, 0, 0};
            else if (st && entry_ok) begin
                m_mode = 1;
                m_load = 1;
            end else if (kv && kd <= 9) begin
                m_d[0] = m_d[1];
                m_d[1] = m_d[2];
                m_d[2] = m_d[3];
                m_d[3] = int'(kd);
            end
        end else if (m_mode == 1) begin
            if (sc) m_mode = 2;
            else if (tz && prev_load == 0) begin
                m_mode  = 3;
                m_ticks = 0;
            end else if (!dc) m_mode = 2;
        end else if (m_mode == 2) begin
            if (sc) begin
                m_mode = 0;
                m_d    = '{0, 0, 0, 0};
            end else if (st && dc) m_mode = 1;
        end else begin
            if (tk) m_ticks++;
            if (sc || m_ticks == 3) begin
                m_mode = 0;
                m_d    = '{0, 0, 0, 0};
            end
        end

        e.preset = 16'(m_d[0] * 4096 + m_d[1] * 256 + m_d[2] * 16 + m_d[3]);
        e.load   = (m_load != 0);
        e.mag    = (m_mode == 1);
        e.lamp   = (m_mode == 0) ? !dc : (m_mode != 3);
        e.beep   = (m_mode == 3);
        e.state  = 2'(m_mode);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, door, 1'b0);
    endtask

    task automatic key(input bit [3:0] d);
        issue(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, door, 1'b0);
    endtask

    task automatic pulse(input bit tk, input bit st, input bit sc, input bit tz);
        issue(1'b0, tk, 1'b0, 4'd0, st, sc, door, tz);
    endtask

    // Monitor: count_en just before each edge, registered outputs just after it.
    initial begin
        exp_t e;
        logic ce_pre;
        forever begin
            @(negedge clk);
            #4;
            ce_pre = mw.count_en;
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("count_en",  int'(ce_pre),       int'(e.ce));
                chk("state",     int'(mw.state),     int'(e.state));
                chk("preset",    int'(mw.preset),    int'(e.preset));
                chk("load",      int'(mw.load),      int'(e.load));
                chk("magnetron", int'(mw.magnetron), int'(e.mag));
                chk("lamp",      int'(mw.lamp),      int'(e.lamp));
                chk("beep",      int'(mw.beep),      int'(e.beep));
            end
        end
    end

    initial begin
        mw.tick = 1'b0; mw.key_valid = 1'b0; mw.key_digit = 4'd0; mw.start = 1'b0;
        mw.stop_clr = 1'b0; mw.door_closed = 1'b1; mw.timer_zero = 1'b0;

        issue(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, door, 1'b0);
        issue(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, door, 1'b0);

        // 01:30 cook, tick on the load cycle, pause by door, resume, finish, beep out.
        key(4'd0); key(4'd1); key(4'd3); key(4'd0);
        key(4'd12);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        door = 1'b0; idle(2);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        door = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(2);
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(1);

        // 99 has sec_tens 9: start must be rejected.
        key(4'd9); key(4'd9);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);

        // stop beats timer_zero, second stop clears.
        key(4'd1); key(4'd2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);

        // Door open in idle drives the lamp; start with door open is rejected.
        key(4'd5);
        door = 1'b0; pulse(1'b0, 1'b1, 1'b0, 1'b0);
        door = 1'b1; pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, door, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) door = ~door;
            issue($urandom_range(0, 199) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 39) == 0,
                  door,
                  $urandom_range(0, 24) == 0);
        end

        idle(1);
        repeat (3) @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port tick, input, 1 bit: 1 Hz enable pulse, high for one clk cycle.
REQ-004 The block SHALL have the port key_valid, input, 1 bit: keypad strobe, high for one cycle per keypress.
REQ-005 The block SHALL have the port key_digit, input, 4 bits: BCD keypad digit, qualified by key_valid.
REQ-006 The block SHALL have the port start, input, 1 bit: start/resume pulse.
REQ-007 The block SHALL have the port stop_clr, input, 1 bit: stop/clear pulse.
REQ-008 The block SHALL have the port door_closed, input, 1 bit: level, 1 = door closed.
REQ-009 The block SHALL have the port timer_zero, input, 1 bit: from the mm:ss counter chain, 1 when all digits are 0.
REQ-010 The block SHALL have the port preset, output, 16 bits: BCD entry {min_tens, min_units, sec_tens, sec_units} driven to the counter chain load inputs.
REQ-011 The block SHALL have the port load, output, 1 bit: one-cycle pulse; the counter chain loads preset.
REQ-012 The block SHALL have the port count_en, output, 1 bit: decrement enable to the counter chain.
REQ-013 The block SHALL have the port magnetron, output, 1 bit: heater on.
REQ-014 The block SHALL have the port lamp, output, 1 bit: cavity lamp.
REQ-015 The block SHALL have the port beep, output, 1 bit: buzzer.
REQ-016 The block SHALL have the port state, output, 2 bits: IDLE=0, COOK=1, PAUSE=2, DONE=3.

Function
REQ-017 The state machine SHALL have exactly four states: IDLE, COOK, PAUSE, DONE; all outputs SHALL be registered except count_en.
REQ-018 In IDLE, each key_valid with key_digit<=9 SHALL shift preset left by 4 bits and insert key_digit at sec_units; key_digit>9 SHALL be ignored; keys in any other state SHALL be ignored.
REQ-019 In IDLE, start SHALL be accepted only if door_closed=1, preset!=0, and sec_tens<=5; otherwise it SHALL be ignored with no output change.
REQ-020 An accepted start SHALL assert load for exactly the next cycle and enter COOK on that same edge.
REQ-021 In COOK, the outputs SHALL be magnetron=1 and lamp=1, and count_en SHALL equal tick & (state==COOK) & door_closed & ~load (combinational).
REQ-022 In COOK, timer_zero=1 while load=0 SHALL transition to DONE next cycle with magnetron=0.
REQ-023 In COOK, door_closed=0 or stop_clr SHALL transition to PAUSE with magnetron=0; the counter chain is not reloaded.
REQ-024 In PAUSE, the outputs SHALL be lamp=1 and magnetron=0; start with door_closed=1 SHALL return to COOK without a load pulse; stop_clr SHALL return to IDLE and clear preset to 0.
REQ-025 In DONE, beep=1 and lamp=0; an internal 2-bit counter SHALL count tick pulses; on the 3rd tick, or on stop_clr, the block SHALL go to IDLE with beep=0 and preset=0.
REQ-026 In IDLE, stop_clr SHALL clear preset to 0, and lamp SHALL equal ~door_closed.
REQ-027 Simultaneous-event priority SHALL be: stop_clr > timer_zero > door open > start > key_valid.
REQ-028 tick coincident with the COOK entry edge SHALL NOT decrement, because count_en is masked by load.

Reset
REQ-029 When rst=1 at a clk edge, the block SHALL enter IDLE with preset=0, load=0, magnetron=0, beep=0, the DONE counter at 0, and lamp=~door_closed on the next cycle; this SHALL also apply mid-COOK.
REQ-030 rst SHALL take priority over all other inputs.

Verification
REQ-031 Keys 0,1,3,0 followed by start with the door closed -> preset=16'h0130, load high for 1 cycle, state=1, magnetron=1; count_en pulses only on tick.
REQ-032 Keys 9,9 followed by start -> preset=16'h0099 (sec_tens=9), start is rejected, and state stays 0.
REQ-033 In COOK, drive door_closed=0 -> state=2, magnetron=0, count_en=0; then door_closed=1 plus start -> state=1 with no load pulse.
REQ-034 In COOK, drive timer_zero=1 -> state=3, beep=1; after 3 tick pulses -> state=0, beep=0, preset=0.
REQ-035 stop_clr and timer_zero in the same cycle during COOK -> state=2 (stop wins); a second stop_clr -> state=0, preset=0.
REQ-036 rst asserted mid-COOK -> the next cycle has state=0, magnetron=0, preset=0, and count_en=0.
